// File: rtl/vdp_pkg.sv
// Shared types and constants for the VDP control/data port initiator.
package vdp_pkg;

  typedef enum logic [1:0] {
    VRAM_RD = 2'd0,
    VRAM_WR = 2'd1,
    REG_WR  = 2'd2,
    CRAM_WR = 2'd3
  } vdp_op_t;

  // Top two bits of the second control byte when writing a VDP register.
  localparam logic [1:0] REG_WR_PREFIX = 2'b10;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic op_is_write(input vdp_op_t op);
    return (op == VRAM_WR) || (op == CRAM_WR);
  endfunction

endpackage

// File: rtl/vdp_phase_timer.sv
// Loadable down-counter shared by the GO, REC and RD_WAIT phases.
// Load with (cycles - 1); done is high on the last cycle of the phase.
module vdp_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Reload on phase entry, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/vdp_port_master.sv
// CPU-side initiator for the VDP control/data port: turns commands and
// streamed beats into paced byte transfers on MODE/CSR_L/CSW_L/vdp_go.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no stream context, waiting for a command
// C1_SETUP | first control byte: MODE/data/CSW_L driven, go low
// C1_GO    | first control byte: go high
// C1_REC   | first control byte: recovery, go low, strobe released
// C2_SETUP | second control byte setup
// C2_GO    | second control byte go pulse
// C2_REC   | second control byte recovery
// STREAM   | address set up, accepting commands / data beats / read requests
// D_SETUP  | data byte setup (MODE=0, CSW_L or CSR_L low)
// D_GO     | data byte go pulse
// D_REC    | data byte recovery
// RD_WAIT  | waiting out the VDP read latency
// RD_CAP   | sampling vdp_data_in
module vdp_port_master
  import vdp_pkg::*;
#(
  parameter int GO_HIGH_CYC = 2,
  parameter int GO_LOW_CYC  = 2,
  parameter int RD_LAT      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [13:0] cmd_addr,
  input  logic [7:0]  cmd_reg_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_data,
  input  logic        rd_req,
  output logic        rd_ack,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        busy,
  output logic        MODE,
  output logic        CSR_L,
  output logic        CSW_L,
  output logic        vdp_go,
  output logic [7:0]  vdp_data_out,
  input  logic [7:0]  vdp_data_in
);

  localparam int TW = $clog2(max3(GO_HIGH_CYC, GO_LOW_CYC, RD_LAT)) + 1;
  // RD_LAT is measured from the go falling edge, so the recovery phase
  // already covers part of it; RD_WAIT only makes up the remainder.
  localparam int RD_WAIT_CYC = (RD_LAT > GO_LOW_CYC) ? (RD_LAT - GO_LOW_CYC) : 1;
  localparam logic [TW-1:0] LD_GO  = TW'(GO_HIGH_CYC - 1);
  localparam logic [TW-1:0] LD_REC = TW'(GO_LOW_CYC - 1);
  localparam logic [TW-1:0] LD_RDW = TW'(RD_WAIT_CYC - 1);

  typedef enum logic [3:0] {
    IDLE, C1_SETUP, C1_GO, C1_REC, C2_SETUP, C2_GO, C2_REC,
    STREAM, D_SETUP, D_GO, D_REC, RD_WAIT, RD_CAP
  } state_t;

  state_t      state_q, state_d;
  vdp_op_t     op_q, op_d, new_op;
  logic [7:0]  byte2_q, byte2_d;
  logic        rd_dir_q, rd_dir_d;
  logic        mode_q, mode_d;
  logic [7:0]  dout_q, dout_d;
  logic        go_q, go_d;
  logic        csw_l_q, csw_l_d;
  logic        csr_l_q, csr_l_d;
  logic        busy_q, busy_d;
  logic        rd_valid_q;
  logic [7:0]  rd_data_q;
  logic        tmr_load, tmr_done;
  logic [TW-1:0] tmr_val;

  vdp_phase_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  assign new_op = vdp_op_t'(cmd_op);

  // Handshakes, next state, command latch and pin values for the next cycle.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    byte2_d  = byte2_q;
    rd_dir_d = rd_dir_q;
    mode_d   = mode_q;
    dout_d   = dout_q;
    tmr_load = 1'b0;
    tmr_val  = '0;

    cmd_ready = (state_q == IDLE) || (state_q == STREAM);
    wr_ready  = (state_q == STREAM) && !cmd_valid && op_is_write(op_q);
    rd_ack    = (state_q == STREAM) && !cmd_valid && (op_q == VRAM_RD);

    if (cmd_valid && cmd_ready) begin
      state_d = C1_SETUP;
      op_d    = new_op;
      mode_d  = 1'b1;
      if (new_op == REG_WR) begin
        dout_d  = cmd_reg_data;
        byte2_d = {REG_WR_PREFIX, 2'b00, cmd_addr[3:0]};
      end else begin
        dout_d  = cmd_addr[7:0];
        byte2_d = {cmd_op, cmd_addr[13:8]};
      end
    end else begin
      case (state_q)
        STREAM: begin
          if (wr_valid && wr_ready) begin
            state_d  = D_SETUP;
            mode_d   = 1'b0;
            dout_d   = wr_data;
            rd_dir_d = 1'b0;
          end else if (rd_req && rd_ack) begin
            state_d  = D_SETUP;
            mode_d   = 1'b0;
            rd_dir_d = 1'b1;
          end
        end
        C1_SETUP, C2_SETUP, D_SETUP: begin
          state_d  = (state_q == C1_SETUP) ? C1_GO : (state_q == C2_SETUP) ? C2_GO : D_GO;
          tmr_load = 1'b1;
          tmr_val  = LD_GO;
        end
        C1_GO, C2_GO, D_GO: begin
          if (tmr_done) begin
            state_d  = (state_q == C1_GO) ? C1_REC : (state_q == C2_GO) ? C2_REC : D_REC;
            tmr_load = 1'b1;
            tmr_val  = LD_REC;
          end
        end
        C1_REC: begin
          if (tmr_done) begin
            state_d = C2_SETUP;
            dout_d  = byte2_q;
          end
        end
        C2_REC: begin
          if (tmr_done) begin
            state_d = (op_q == REG_WR) ? IDLE : STREAM;
          end
        end
        D_REC: begin
          if (tmr_done) begin
            if (rd_dir_q) begin
              state_d  = RD_WAIT;
              tmr_load = 1'b1;
              tmr_val  = LD_RDW;
            end else begin
              state_d = STREAM;
            end
          end
        end
        RD_WAIT: begin
          if (tmr_done) begin
            state_d = RD_CAP;
          end
        end
        RD_CAP: state_d = STREAM;
        default: state_d = state_q;
      endcase
    end

    go_d    = state_d inside {C1_GO, C2_GO, D_GO};
    csw_l_d = !((state_d inside {C1_SETUP, C1_GO, C2_SETUP, C2_GO}) ||
                ((state_d inside {D_SETUP, D_GO}) && !rd_dir_d));
    csr_l_d = !((state_d inside {D_SETUP, D_GO}) && rd_dir_d);
    busy_d  = state_d inside {C1_SETUP, C1_GO, C1_REC, C2_SETUP, C2_GO, C2_REC,
                              D_SETUP, D_GO, D_REC};
  end

  // State, command latch and registered port pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= VRAM_RD;
      byte2_q    <= '0;
      rd_dir_q   <= 1'b0;
      mode_q     <= 1'b1;
      dout_q     <= '0;
      go_q       <= 1'b0;
      csw_l_q    <= 1'b1;
      csr_l_q    <= 1'b1;
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      byte2_q    <= byte2_d;
      rd_dir_q   <= rd_dir_d;
      mode_q     <= mode_d;
      dout_q     <= dout_d;
      go_q       <= go_d;
      csw_l_q    <= csw_l_d;
      csr_l_q    <= csr_l_d;
      busy_q     <= busy_d;
      rd_valid_q <= (state_q == RD_CAP);
      if (state_q == RD_CAP) begin
        rd_data_q <= vdp_data_in;
      end
    end
  end

  assign MODE         = mode_q;
  assign vdp_data_out = dout_q;
  assign vdp_go       = go_q;
  assign CSW_L        = csw_l_q;
  assign CSR_L        = csr_l_q;
  assign busy         = busy_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;

endmodule

// File: doc/vdp_port_master.md
Name: vdp_port_master

Overview:
CPU-side initiator for the VDP control/data port protocol. It turns abstract commands (register write, VRAM read/write setup, CRAM write setup) and streamed data beats into correctly paced byte transfers on the MODE/CSR_L/CSW_L/go/data port pins. It sits between the CPU bus adapter (or a test/DMA sequencer) and the VDP's port interface, and is the sole driver of those pins.

Parameters:
GO_HIGH_CYC, 2, cycles vdp_go is held high per byte (≥1)
GO_LOW_CYC, 2, recovery cycles with vdp_go low after each byte (≥2)
RD_LAT, 4, cycles after vdp_go falls before vdp_data_in is sampled on a read (≥3)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  2  vdp_op_t: 0 VRAM_RD, 1 VRAM_WR, 2 REG_WR, 3 CRAM_WR
cmd_addr  in  14  VRAM/CRAM address; for REG_WR, [3:0] = register index
cmd_reg_data  in  8  REG_WR value
wr_valid  in  1  write data beat offered
wr_ready  out  1  write beat accepted
wr_data  in  8  write beat byte
rd_req  in  1  request one read byte
rd_ack  out  1  rd_req accepted
rd_valid  out  1  1-cycle pulse, rd_data valid
rd_data  out  8  read byte
busy  out  1  a byte transfer is in progress
MODE  out  1  1 = control port, 0 = data port
CSR_L  out  1  read strobe, active low
CSW_L  out  1  write strobe, active low
vdp_go  out  1  byte transfer pulse
vdp_data_out  out  8  byte to VDP
vdp_data_in  in  8  byte from VDP

Behaviour:
- Reset values: MODE=1, CSR_L=1, CSW_L=1, vdp_go=0, vdp_data_out=0, rd_data=0, rd_valid=0, busy=0. After release the block is in IDLE with cmd_ready=1. Reset mid-transfer drops vdp_go immediately and discards the command and the stream context.
- Byte cycle: SETUP (1 cycle; drive MODE, vdp_data_out and strobe, go=0), then GO (GO_HIGH_CYC cycles, go=1), then REC (GO_LOW_CYC cycles, go=0, strobe deasserted). That is 1+GO_HIGH_CYC+GO_LOW_CYC cycles per byte. MODE and vdp_data_out hold their values until the next SETUP. busy=1 from SETUP through REC.
- Command encoding: byte1 = cmd_addr[7:0], or cmd_reg_data for REG_WR. byte2 = {cmd_op, cmd_addr[13:8]}, or {2'b10, 2'b00, cmd_addr[3:0]} for REG_WR. Both bytes are sent with MODE=1 and CSW_L=0. The command is latched at the acceptance edge.
- States: IDLE, C1_SETUP, C1_GO, C1_REC, C2_SETUP, C2_GO, C2_REC, STREAM, D_SETUP, D_GO, D_REC, RD_WAIT, RD_CAP.
- Transitions:
  - IDLE: cmd accept -> C1_SETUP.
  - C2_REC: -> IDLE for REG_WR, else -> STREAM.
  - STREAM, priority is cmd > wr > rd:
    - cmd accept -> C1_SETUP.
    - wr beat accepted, only when op ∈ {VRAM_WR, CRAM_WR} -> D_SETUP, with MODE=0, CSW_L=0, vdp_data_out=wr_data.
    - rd_req accepted, only when op=VRAM_RD -> D_SETUP, with MODE=0, CSR_L=0.
  - D_REC: write -> STREAM. Read -> RD_WAIT, which counts RD_LAT cycles from the vdp_go falling edge, then RD_CAP.
  - RD_CAP: rd_data <= vdp_data_in, rd_valid=1 for one cycle, -> STREAM.
- Ready rules: cmd_ready=1 only in IDLE/STREAM. wr_ready/rd_ack are each 1 only in STREAM, when the op matches, and when no higher-priority request is present. A beat offered against a mismatched op is never accepted: it stays pending until a matching command is issued.
- Address auto-increment is the VDP's job; this block never re-sends the address for sequential beats.
- Timer counters are sized $clog2(max(GO_HIGH_CYC,GO_LOW_CYC,RD_LAT))+1 bits and reload at every phase entry.

Decomposition:
- vdp_pkg holds the vdp_op_t enum (VRAM_RD=0, VRAM_WR=1, REG_WR=2, CRAM_WR=3) and the REG_WR byte2 prefix constant 2'b10.
- One sub-module: vdp_phase_timer, a loadable down-counter with a done flag, shared by the GO, REC and RD_WAIT phases.
- Top module holds the FSM, the command/op latch, the output registers and the read capture.

Test Plan:
- Reset: assert rst mid-C1_GO -> vdp_go=0 the same cycle, MODE=1, strobes=1, cmd_ready=1 after release.
- REG_WR reg=7, data=0x3C: vdp_data_out=0x3C then 0x87 with MODE=1, exactly 2 vdp_go pulses of 2 cycles each, cmd_ready back 10 cycles after acceptance.
- VRAM_WR addr=0x3FFE, then beats 0xAA, 0x55: bytes 0xFE, 0x7F (MODE=1), then 0xAA, 0x55 (MODE=0, CSW_L=0), one go pulse per byte, wr_ready only in STREAM.
- VRAM_RD addr=0x0100, 2 rd_req, VDP model returns 0x11, 0x22: bytes 0x00, 0x01, then 2 MODE=0/CSR_L=0 go pulses, rd_valid pulses with rd_data 0x11 then 0x22, each RD_LAT+1 cycles after go falls.
- STREAM with cmd_valid and wr_valid asserted in the same cycle: command accepted, write beat held off until the new command completes.
- CRAM_WR stream with wr_valid offered, then an interleaved rd_req: rd_ack never asserts, rd_req stays pending, no CSR_L activity.
